mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one backing memory port between the instruction-fetch path (read-only) and the data path (read/write).
//  Sits between mips_core and the shared memory. Per-requester stall outputs feed the core's rom_stall/ram_stall inputs.
//  Data has priority over fetch. A streak limiter prevents fetch starvation. A watchdog bounds a hung memory.
// PARAMETERS
//  ADDR_W        32  address width, all ports
//  DATA_W        32  data width, all ports
//  MAX_D_STREAK  4   max consecutive data grants while fetch waits (range 1..15)
//  TIMEOUT       64  cycles in BUSY without m_ack before abort (range 2..255)
// PORTS
//  clk      in   1       single clock; all logic on rising edge
//  rst_n    in   1       asynchronous, active-low reset
//  i_req    in   1       fetch request; held with i_addr until i_ack
//  i_addr   in   ADDR_W  fetch address
//  i_rdata  out  DATA_W  fetch read data; valid while i_ack=1
//  i_ack    out  1       one-cycle fetch completion pulse
//  i_stall  out  1       i_req & ~i_ack (combinational)
//  d_req    in   1       data request; held with d_we/d_addr/d_wdata until d_ack
//  d_we     in   1       1 = write, 0 = read
//  d_addr   in   ADDR_W  data address
//  d_wdata  in   DATA_W  write data
//  d_rdata  out  DATA_W  data read result; valid while d_ack=1 (0 for writes)
//  d_ack    out  1       one-cycle data completion pulse
//  d_stall  out  1       d_req & ~d_ack (combinational)
//  m_req    out  1       memory request; registered; held until m_ack or timeout
//  m_we     out  1       memory write enable; 0 for fetch
//  m_addr   out  ADDR_W  memory address (registered)
//  m_wdata  out  DATA_W  memory write data (registered)
//  m_rdata  in   DATA_W  memory read data; sampled when m_ack=1
//  m_ack    in   1       memory completion; ignored unless state is I_BUSY/D_BUSY
//  err      out  1       sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; streak=0; wdog=0. All outputs 0, including m_req, acks and err.
//  Reset is asynchronous: an in-flight m_req drops immediately and the transaction is lost (no ack).
//  States: IDLE, I_BUSY, D_BUSY, RESP.
//  IDLE arbitration, evaluated each cycle:
//   - d_req & (~i_req | streak<MAX_D_STREAK): latch d_we/d_addr/d_wdata, go to D_BUSY.
//   - else if i_req: latch i_addr with m_we=0, go to I_BUSY.
//   - else stay in IDLE.
//  Streak counter:
//   - D grant with i_req=1: streak+1, saturating at MAX_D_STREAK.
//   - I grant, or any IDLE cycle with i_req=0: streak=0.
//  I_BUSY/D_BUSY:
//   - m_req=1; m_* are stable for the whole state. wdog increments each cycle.
//   - m_ack=1: capture m_rdata into the owner's rdata (d_rdata=0 for writes), drop m_req, go to RESP.
//   - wdog reaches TIMEOUT-1 with no m_ack: drop m_req, rdata=0, set err, go to RESP.
//  RESP: owner's ack=1 for exactly one cycle. No arbitration here, so a req still high is not re-granted. Next state IDLE; wdog=0.
//  Latency:
//   - req seen in IDLE at cycle 0; m_req high in cycle 1.
//   - m_ack in cycle k gives ack in cycle k+1. Minimum is 2 cycles req-to-ack.
//   - Back-to-back grants are at most one per 3 cycles.
//  Only one transaction is outstanding; the non-owner's ack stays 0 and its stall stays 1.
//  Simultaneous i_req and d_req in IDLE: data wins unless streak==MAX_D_STREAK.
//  Requests that drop before ack are a protocol violation. The latched copy is completed regardless.
// TESTING
//  1. Single data write, addr=0x10, wdata=0xA5A5A5A5, mem acks in cycle 1 -> m_we=1, m_addr=0x10; d_ack in cycle 2; i_ack stays 0.
//  2. i_req and d_req high together from IDLE, MAX_D_STREAK=4, d_req re-asserted continuously -> 4 data grants, then a fetch grant; streak returns to 0.
//  3. Fetch read, addr=0x400, mem returns 0x8C080004 after 5 cycles -> i_rdata=0x8C080004 with i_ack for exactly 1 cycle; i_stall=1 until then.
//  4. Memory never acks, TIMEOUT=64 -> m_req drops after 64 BUSY cycles; ack pulses with rdata=0; err=1 and stays 1.
//  5. Assert rst_n=0 mid D_BUSY -> m_req, acks and err go to 0 asynchronously; after release the next request is served normally.
//  6. Spurious m_ack in IDLE/RESP -> no state change, no ack, rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] streak;
  logic [7:0] wdog;

  // Stalls follow the request directly so the core freezes in the same cycle it asks.
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

  // Arbitration, memory handshake, watchdog and response pulse in one registered FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      streak  <= '0;
      wdog    <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Data wins unless it has already taken MAX_D_STREAK grants past a waiting fetch.
          if (d_req && (!i_req || streak < STREAK_MAX)) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            wdog    <= '0;
            state   <= D_BUSY;
            streak  <= i_req ? streak + 4'd1 : 4'd0;
          end else if (i_req) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            wdog    <= '0;
            state   <= I_BUSY;
            streak  <= '0;
          end else begin
            streak  <= '0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= RESP;
            if (state == I_BUSY) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= m_we ? '0 : m_rdata;
              d_ack   <= 1'b1;
            end
          end else if (wdog == WDOG_LAST) begin
            // Hung memory: abandon the access, complete with zero data and flag it.
            m_req <= 1'b0;
            err   <= 1'b1;
            state <= RESP;
            if (state == I_BUSY) begin
              i_rdata <= '0;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        RESP: begin
          // No arbitration here, so a still-held request cannot be re-granted this cycle.
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          wdog  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
